// File: rtl/fwd_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// fwd_hazard_ctrl
//   Forwarding and load-use hazard control for an RV32I execute stage.
//   A shadow pipeline records {valid, rd, regwrite, is_load} for the
//   instructions in EX and MEM. The registered select pair steers the two EX
//   operand muxes: 00 = register file, 01 = EX/MEM result, 10 = MEM/WB result.
//   A load in EX whose rd is read by the instruction in ID raises a
//   combinational stall and a bubble is inserted into EX.
//
//   Instructions leaving MEM enter WB, but no WB entry is kept: the register
//   file is write-first, so an ID read in the same cycle as the WB write
//   already sees the new value and a WB producer never needs a forward.
//
// Optional feature (macro FWD_PERF_CNT_EN):
//   Adds saturating counters perf_stall_cnt (stall edges) and perf_fwd_cnt
//   (nonzero selects written). Without the macro the ports do not exist.
//
// Ports:
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   id_valid       in   ID holds a valid instruction
//   id_rs1/id_rs2  in   ID source registers
//   id_use_rs1/2   in   ID instruction reads rs1/rs2
//   id_rd          in   ID destination register
//   id_regwrite    in   ID instruction writes rd
//   id_is_load     in   ID instruction is a load
//   flush          in   squash ID and EX (branch/jump resolved in EX)
//   ext_hold       in   global freeze, all state holds
//   load_use_stall out  combinational stall request for ID and PC
//   fwd_a_sel      out  registered select for EX operand A
//   fwd_b_sel      out  registered select for EX operand B
//   perf_stall_cnt out  (FWD_PERF_CNT_EN only) stall counter
//   perf_fwd_cnt   out  (FWD_PERF_CNT_EN only) forward counter
// -----------------------------------------------------------------------------
module fwd_hazard_ctrl #(
   parameter int RAW = 5
`ifdef FWD_PERF_CNT_EN
   ,
   parameter int CNT_W = 32
`endif
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           id_valid,
   input  logic [RAW-1:0] id_rs1,
   input  logic [RAW-1:0] id_rs2,
   input  logic           id_use_rs1,
   input  logic           id_use_rs2,
   input  logic [RAW-1:0] id_rd,
   input  logic           id_regwrite,
   input  logic           id_is_load,
   input  logic           flush,
   input  logic           ext_hold,
   output logic           load_use_stall,
   output logic [1:0]     fwd_a_sel,
   output logic [1:0]     fwd_b_sel
`ifdef FWD_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] perf_stall_cnt,
   output logic [CNT_W-1:0] perf_fwd_cnt
`endif
);

   localparam logic [1:0] SEL_RF  = 2'b00;
   localparam logic [1:0] SEL_MEM = 2'b01;
   localparam logic [1:0] SEL_WB  = 2'b10;

   // x0 is hardwired to zero, so it is never a forwarding producer.
   function automatic logic f_match(input logic           vld,
                                    input logic           rw,
                                    input logic [RAW-1:0] rd,
                                    input logic [RAW-1:0] rs);
      return vld && rw && (rd != '0) && (rd == rs);
   endfunction

   // Shadow entries: _p0 = EX, _p1 = MEM
   logic           r_vld_p0, r_vld_p1;
   logic [RAW-1:0] r_rd_p0,  r_rd_p1;
   logic           r_rw_p0,  r_rw_p1;
   logic           r_ld_p0,  r_ld_p1;
   logic [1:0]     r_fwd_a_sel, r_fwd_b_sel;

   logic           w_ex_hit_a, w_ex_hit_b;
   logic           w_mem_hit_a, w_mem_hit_b;
   logic           w_stall;
   logic [1:0]     w_sel_a, w_sel_b;

   // ID decode against the EX and MEM entries
   always_comb begin
      w_ex_hit_a  = id_use_rs1 && f_match(r_vld_p0, r_rw_p0, r_rd_p0, id_rs1);
      w_ex_hit_b  = id_use_rs2 && f_match(r_vld_p0, r_rw_p0, r_rd_p0, id_rs2);
      w_mem_hit_a = id_use_rs1 && f_match(r_vld_p1, r_rw_p1, r_rd_p1, id_rs1);
      w_mem_hit_b = id_use_rs2 && f_match(r_vld_p1, r_rw_p1, r_rd_p1, id_rs2);

      // A flush squashes the ID instruction, so it cannot stall.
      w_stall = id_valid && !flush && r_ld_p0 && (w_ex_hit_a || w_ex_hit_b);

      // Nearest producer wins; a load in EX has no result yet and is
      // handled by the stall instead of a forward.
      w_sel_a = SEL_RF;
      if (id_valid && id_use_rs1) begin
         if (w_ex_hit_a && !r_ld_p0) begin
            w_sel_a = SEL_MEM;
         end else if (w_mem_hit_a) begin
            w_sel_a = SEL_WB;
         end
      end

      w_sel_b = SEL_RF;
      if (id_valid && id_use_rs2) begin
         if (w_ex_hit_b && !r_ld_p0) begin
            w_sel_b = SEL_MEM;
         end else if (w_mem_hit_b) begin
            w_sel_b = SEL_WB;
         end
      end
   end

   assign load_use_stall = w_stall;
   assign fwd_a_sel      = r_fwd_a_sel;
   assign fwd_b_sel      = r_fwd_b_sel;

   // ID -> EX -> MEM: valid bits and selects (reset)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld_p0    <= 1'b0;
         r_vld_p1    <= 1'b0;
         r_fwd_a_sel <= SEL_RF;
         r_fwd_b_sel <= SEL_RF;
      end else if (!ext_hold) begin
         if (flush) begin
            r_vld_p0    <= 1'b0;
            r_vld_p1    <= 1'b0;
            r_fwd_a_sel <= SEL_RF;
            r_fwd_b_sel <= SEL_RF;
         end else if (w_stall) begin
            r_vld_p1    <= r_vld_p0;
            r_vld_p0    <= 1'b0;
            r_fwd_a_sel <= SEL_RF;
            r_fwd_b_sel <= SEL_RF;
         end else begin
            r_vld_p1    <= r_vld_p0;
            r_vld_p0    <= id_valid;
            r_fwd_a_sel <= w_sel_a;
            r_fwd_b_sel <= w_sel_b;
         end
      end
   end

   // ID -> EX -> MEM: entry payload (qualified by the valid bits)
   always_ff @(posedge clk) begin
      if (!ext_hold && !flush) begin
         r_rd_p1 <= r_rd_p0;
         r_rw_p1 <= r_rw_p0;
         r_ld_p1 <= r_ld_p0;
         if (!w_stall) begin
            r_rd_p0 <= id_rd;
            r_rw_p0 <= id_regwrite;
            r_ld_p0 <= id_is_load;
         end
      end
   end

`ifdef FWD_PERF_CNT_EN
   function automatic logic [CNT_W-1:0] f_sat_add(input logic [CNT_W-1:0] cnt,
                                                  input logic [1:0]       inc);
      logic [CNT_W:0] sum;
      sum = {1'b0, cnt} + (CNT_W+1)'(inc);
      return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   endfunction

   logic [CNT_W-1:0] r_stall_cnt, r_fwd_cnt;
   logic [1:0]       w_fwd_inc;

   // Only selects actually written on a normal advance are counted.
   always_comb begin
      w_fwd_inc = 2'd0;
      if (!flush && !w_stall) begin
         w_fwd_inc = {1'b0, (w_sel_a != SEL_RF)} + {1'b0, (w_sel_b != SEL_RF)};
      end
   end

   // Counter update on each unheld edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
         r_fwd_cnt   <= '0;
      end else if (!ext_hold) begin
         r_stall_cnt <= f_sat_add(r_stall_cnt, {1'b0, w_stall});
         r_fwd_cnt   <= f_sat_add(r_fwd_cnt, w_fwd_inc);
      end
   end

   assign perf_stall_cnt = r_stall_cnt;
   assign perf_fwd_cnt   = r_fwd_cnt;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fwd_hazard_ctrl
//   Directed bench for fwd_hazard_ctrl. Instructions are driven into ID just
//   after a rising edge; registered selects are sampled 1 time unit after the
//   edge, the combinational stall 1 time unit after the inputs change.
// -----------------------------------------------------------------------------
module tb_fwd_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       id_valid;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic       id_use_rs1, id_use_rs2;
   logic       id_regwrite, id_is_load;
   logic       flush, ext_hold;
   logic       load_use_stall;
   logic [1:0] fwd_a_sel, fwd_b_sel;
`ifdef FWD_PERF_CNT_EN
   logic [31:0] perf_stall_cnt, perf_fwd_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fwd_hazard_ctrl #(.RAW(5)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .id_valid       (id_valid),
      .id_rs1         (id_rs1),
      .id_rs2         (id_rs2),
      .id_use_rs1     (id_use_rs1),
      .id_use_rs2     (id_use_rs2),
      .id_rd          (id_rd),
      .id_regwrite    (id_regwrite),
      .id_is_load     (id_is_load),
      .flush          (flush),
      .ext_hold       (ext_hold),
      .load_use_stall (load_use_stall),
      .fwd_a_sel      (fwd_a_sel),
      .fwd_b_sel      (fwd_b_sel)
`ifdef FWD_PERF_CNT_EN
      ,
      .perf_stall_cnt (perf_stall_cnt),
      .perf_fwd_cnt   (perf_fwd_cnt)
`endif
   );

   task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic rw, input logic ld);
      id_valid    = v;
      id_rs1      = rs1;
      id_rs2      = rs2;
      id_use_rs1  = u1;
      id_use_rs2  = u2;
      id_rd       = rd;
      id_regwrite = rw;
      id_is_load  = ld;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; ext_hold = 1'b0;
      drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      #2;
      checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL reset_a got %b exp 00", fwd_a_sel); end
      checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL reset_b got %b exp 00", fwd_b_sel); end
      checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", load_use_stall); end
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_fwd_ex();
      drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);   // add x5,x1,x2
      step();
      drive(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);   // add x6,x5,x1
      #1;
      checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL ex_stall got %b exp 0", load_use_stall); end
      step();
      checks++; if (fwd_a_sel !== 2'b01) begin errors++; $display("FAIL ex_a got %b exp 01", fwd_a_sel); end
      checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL ex_b got %b exp 00", fwd_b_sel); end
   endtask

   task automatic test_fwd_mem();
      drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);   // add x5
      step();
      drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);   // nop
      step();
      drive(1'b1, 5'd2, 5'd5, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);   // sub x7,x2,x5
      step();
      checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL mem_a got %b exp 00", fwd_a_sel); end
      checks++; if (fwd_b_sel !== 2'b10) begin errors++; $display("FAIL mem_b got %b exp 10", fwd_b_sel); end
   endtask

   task automatic test_load_use();
      drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);   // lw x8
      step();
      drive(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);   // add x9,x8,x8
      #1;
      checks++; if (load_use_stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %b exp 1", load_use_stall); end
      step();
      checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL lu_stall_once got %b exp 0", load_use_stall); end
      checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL lu_bubble_a got %b exp 00", fwd_a_sel); end
      checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL lu_bubble_b got %b exp 00", fwd_b_sel); end
      step();
      checks++; if (fwd_a_sel !== 2'b10) begin errors++; $display("FAIL lu_a got %b exp 10", fwd_a_sel); end
      checks++; if (fwd_b_sel !== 2'b10) begin errors++; $display("FAIL lu_b got %b exp 10", fwd_b_sel); end
   endtask

   task automatic test_x0_nearest();
      drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);   // add x0,x1,x2
      step();
      drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);   // add x3,x0,x0
      step();
      checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL x0_ex_a got %b exp 00", fwd_a_sel); end
      checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL x0_ex_b got %b exp 00", fwd_b_sel); end
      drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);  // add x10,x0,x0 (x0 writer now in MEM)
      step();
      checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL x0_mem_a got %b exp 00", fwd_a_sel); end
      checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL x0_mem_b got %b exp 00", fwd_b_sel); end
      drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);   // add x4
      step();
      drive(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);   // add x4
      step();
      drive(1'b1, 5'd4, 5'd4, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);   // add x5,x4,x4
      step();
      checks++; if (fwd_a_sel !== 2'b01) begin errors++; $display("FAIL near_a got %b exp 01", fwd_a_sel); end
      checks++; if (fwd_b_sel !== 2'b01) begin errors++; $display("FAIL near_b got %b exp 01", fwd_b_sel); end
   endtask

   task automatic test_flush();
      drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);  // add x10
      step();
      drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);   // lw x8
      step();
      drive(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);   // add x9,x8,x8
      flush = 1'b1;
      #1;
      checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL fl_stall got %b exp 0", load_use_stall); end
      step();
      flush = 1'b0;
      checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL fl_a got %b exp 00", fwd_a_sel); end
      checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL fl_b got %b exp 00", fwd_b_sel); end
      // MEM and EX were bubbled: neither x10 nor x8 may be forwarded now
      drive(1'b1, 5'd10, 5'd8, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0);
      #1;
      checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL fl_post_stall got %b exp 0", load_use_stall); end
      step();
      checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL fl_post_a got %b exp 00", fwd_a_sel); end
      checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL fl_post_b got %b exp 00", fwd_b_sel); end
   endtask

   task automatic test_hold();
      drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0);  // add x12
      step();
      drive(1'b1, 5'd12, 5'd12, 1'b1, 1'b1, 5'd13, 1'b1, 1'b0); // add x13,x12,x12
      step();
      checks++; if (fwd_a_sel !== 2'b01) begin errors++; $display("FAIL hold_pre_a got %b exp 01", fwd_a_sel); end
      checks++; if (fwd_b_sel !== 2'b01) begin errors++; $display("FAIL hold_pre_b got %b exp 01", fwd_b_sel); end
      drive(1'b1, 5'd13, 5'd12, 1'b1, 1'b1, 5'd14, 1'b1, 1'b0); // add x14,x13,x12
      ext_hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (fwd_a_sel !== 2'b01) begin errors++; $display("FAIL hold_a[%0d] got %b exp 01", i, fwd_a_sel); end
         checks++; if (fwd_b_sel !== 2'b01) begin errors++; $display("FAIL hold_b[%0d] got %b exp 01", i, fwd_b_sel); end
      end
      ext_hold = 1'b0;
      step();
      checks++; if (fwd_a_sel !== 2'b01) begin errors++; $display("FAIL hold_post_a got %b exp 01", fwd_a_sel); end
      checks++; if (fwd_b_sel !== 2'b10) begin errors++; $display("FAIL hold_post_b got %b exp 10", fwd_b_sel); end
   endtask

   task automatic test_hold_stall();
      drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);   // lw x8
      step();
      drive(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);   // add x9,x8,x8
      ext_hold = 1'b1;
      #1;
      checks++; if (load_use_stall !== 1'b1) begin errors++; $display("FAIL hs_stall got %b exp 1", load_use_stall); end
      step();
      checks++; if (load_use_stall !== 1'b1) begin errors++; $display("FAIL hs_stall_held got %b exp 1", load_use_stall); end
      ext_hold = 1'b0;
      step();
      checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL hs_released got %b exp 0", load_use_stall); end
      checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL hs_bubble_a got %b exp 00", fwd_a_sel); end
      step();
      checks++; if (fwd_a_sel !== 2'b10) begin errors++; $display("FAIL hs_a got %b exp 10", fwd_a_sel); end
      checks++; if (fwd_b_sel !== 2'b10) begin errors++; $display("FAIL hs_b got %b exp 10", fwd_b_sel); end
   endtask

   task automatic test_async_reset();
      drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);   // add x5
      step();
      drive(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);   // add x6,x5,x5
      step();
      checks++; if (fwd_a_sel !== 2'b01) begin errors++; $display("FAIL ar_pre_a got %b exp 01", fwd_a_sel); end
      ext_hold = 1'b1;
      flush    = 1'b1;
      #3;
      rst_n = 1'b0;
      #1;
      checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL ar_a got %b exp 00", fwd_a_sel); end
      checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL ar_b got %b exp 00", fwd_b_sel); end
      step();
      rst_n    = 1'b1;
      ext_hold = 1'b0;
      flush    = 1'b0;
      drive(1'b1, 5'd6, 5'd5, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);   // reads x6,x5
      step();
      checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL ar_post_a got %b exp 00", fwd_a_sel); end
      checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL ar_post_b got %b exp 00", fwd_b_sel); end
   endtask

`ifdef FWD_PERF_CNT_EN
   task automatic test_perf();
      drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      #2; rst_n = 1'b0; #2; rst_n = 1'b1;
      step();
      checks++; if (perf_stall_cnt !== 32'd0) begin errors++; $display("FAIL pc_stall0 got %0d exp 0", perf_stall_cnt); end
      checks++; if (perf_fwd_cnt !== 32'd0) begin errors++; $display("FAIL pc_fwd0 got %0d exp 0", perf_fwd_cnt); end
      drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);   // lw x8
      step();
      drive(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);   // add x9,x8,x8
      step();                                                   // stall edge
      step();                                                   // +2 forwards
      drive(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd20, 1'b1, 1'b0);  // writer of x20
      step();
      drive(1'b1, 5'd20, 5'd20, 1'b1, 1'b1, 5'd21, 1'b1, 1'b0); // +2
      step();
      drive(1'b1, 5'd21, 5'd21, 1'b1, 1'b1, 5'd22, 1'b1, 1'b0); // +2
      step();
      drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      checks++; if (perf_stall_cnt !== 32'd1) begin errors++; $display("FAIL pc_stall got %0d exp 1", perf_stall_cnt); end
      checks++; if (perf_fwd_cnt !== 32'd6) begin errors++; $display("FAIL pc_fwd got %0d exp 6", perf_fwd_cnt); end
      checks++; if (fwd_a_sel !== 2'b01) begin errors++; $display("FAIL pc_pre_a got %b exp 01", fwd_a_sel); end
      #2; rst_n = 1'b0; #1;
      checks++; if (perf_stall_cnt !== 32'd0) begin errors++; $display("FAIL pc_rst_stall got %0d exp 0", perf_stall_cnt); end
      checks++; if (perf_fwd_cnt !== 32'd0) begin errors++; $display("FAIL pc_rst_fwd got %0d exp 0", perf_fwd_cnt); end
      checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL pc_rst_a got %b exp 00", fwd_a_sel); end
      #2; rst_n = 1'b1;
      step();
   endtask
`endif

   initial begin
      test_reset();
      test_fwd_ex();
      test_fwd_mem();
      test_load_use();
      test_x0_nearest();
      test_flush();
      test_hold();
      test_hold_stall();
      test_async_reset();
`ifdef FWD_PERF_CNT_EN
      test_perf();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Forwarding and hazard control for the RV32I execute stage.
- Tracks destination registers of in-flight instructions in a shadow EX/MEM/WB pipeline.
- Generates the registered 2-bit select pair driving the two operand 3-way muxes in EX: 00 = register file, 01 = EX/MEM result, 10 = MEM/WB result.
- Detects load-use hazards, requests a one-cycle stall, and inserts a bubble.

Parameters:
- RAW, 5, register address width (x0..x31).
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_valid  input  1  ID holds a valid instruction.
- id_rs1  input  RAW  ID source register 1.
- id_rs2  input  RAW  ID source register 2.
- id_use_rs1  input  1  ID instruction reads rs1.
- id_use_rs2  input  1  ID instruction reads rs2.
- id_rd  input  RAW  ID destination register.
- id_regwrite  input  1  ID instruction writes rd.
- id_is_load  input  1  ID instruction is a load.
- flush  input  1  squash the instructions in ID and EX (taken branch/jump resolved in EX).
- ext_hold  input  1  global freeze (memory wait); all state holds.
- load_use_stall  output  1  combinational; ID and PC must hold this cycle.
- fwd_a_sel  output  2  registered select for EX operand A mux.
- fwd_b_sel  output  2  registered select for EX operand B mux.

Behaviour:
- Internal state: per-stage entries {valid, rd, regwrite, is_load} for EX, MEM and WB.
- Reset: every valid bit = 0. fwd_a_sel = fwd_b_sel = 2'b00. load_use_stall = 0 (no valid EX entry).
- Reset is asynchronous and takes effect mid-operation regardless of ext_hold or flush.
- Producer match in stage S for source rs:
  - S.valid && S.regwrite && S.rd != 0 && S.rd == rs.
  - x0 never matches.
- load_use_stall = id_valid && !flush && EX.is_load && (EX matches rs1 with id_use_rs1, or EX matches rs2 with id_use_rs2).
- Each rising edge with ext_hold = 0, advance in this priority order:
  - flush = 1:
    - MEM ← bubble and EX ← bubble; the squashed EX instruction does not advance.
    - WB ← old MEM.
    - Both selects ← 00.
  - else load_use_stall = 1:
    - WB ← MEM and MEM ← EX.
    - EX ← bubble.
    - Both selects ← 00.
    - ID is re-presented next cycle by the upstream stage.
  - else:
    - WB ← MEM and MEM ← EX.
    - EX ← ID entry, with valid = id_valid.
    - Selects computed per source from the pre-edge state, nearest producer first:
      - 01 if the pre-edge EX entry matches and is not a load.
      - else 10 if the pre-edge MEM entry matches.
      - else 00.
    - A select is 00 if the corresponding id_use_rsX = 0 or id_valid = 0.
- Load followed by a dependent instruction:
  - Exactly one stall cycle.
  - In the following cycle the load sits in MEM and the dependent instruction receives 10.
- WB-stage producers never need forwarding: the register file is write-first, so a same-cycle read in ID sees the written value.
- ext_hold = 1: all entries and both selects hold.
  - load_use_stall is still evaluated combinationally from the held state.
- Selects are never 2'b11.

Optional Feature:
- Macro: FWD_PERF_CNT_EN.
- Defined: adds outputs perf_stall_cnt [CNT_W] and perf_fwd_cnt [CNT_W].
  - Both reset to 0.
  - perf_stall_cnt increments on each edge where load_use_stall = 1 and ext_hold = 0.
  - perf_fwd_cnt increments by the number (0, 1 or 2) of nonzero selects written on that edge.
  - Both counters saturate at all-ones.
- Undefined: these ports and counters are absent.
  - All other behaviour is identical.

Test Plan:
- add x5 then add x6,x5,x1 back-to-back, no hold -> fwd_a_sel = 01, fwd_b_sel = 00, no stall.
- add x5; nop; sub x7,x2,x5 -> fwd_b_sel = 10 on sub's EX cycle.
- lw x8; add x9,x8,x8 -> load_use_stall = 1 for exactly one cycle with both selects 00 during the bubble; next cycle both selects = 10.
- add x0,x1,x2 then add x3,x0,x0 -> selects 00 (x0 never forwarded). Back-to-back writers of x4 then reader of x4 -> 01 (nearest wins).
- flush asserted while a lw x8 sits in EX and its dependent sits in ID -> no stall, MEM/EX bubbles, selects 00. Then ext_hold high for 3 cycles -> selects and entries frozen.
- With FWD_PERF_CNT_EN: run the lw/use pair plus two dual-forward adds -> perf_stall_cnt = 1, perf_fwd_cnt = 6. rst_n pulsed low mid-run -> both counters 0, selects 00 immediately (asynchronous).
